// File: rtl/tile_map_ram.sv
// Tile-map memory for the video subsystem.
// The video fetcher owns the shared read port whenever it asks for it.
// The CPU reaches the map through a valid/ready handshake.
// A fill engine can overwrite every entry with one value.
module tile_map_ram #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 4000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  vid_ren,
  input  logic [ADDR_WIDTH-1:0] vid_addr,
  output logic [DATA_WIDTH-1:0] vid_rdata,
  input  logic                  cpu_valid,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ready,
  input  logic                  fill_start,
  input  logic [DATA_WIDTH-1:0] fill_value,
  output logic                  fill_busy
);

  // Last implemented entry; addresses above it are unbacked.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  // Index width actually needed to address the storage array.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH > (1 << ADDR_WIDTH)) begin : g_depth_check
    $error("tile_map_ram: DEPTH does not fit in ADDR_WIDTH address bits");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    FILL = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_next;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [ADDR_WIDTH-1:0]   fill_cnt;
  logic [DATA_WIDTH-1:0]   fill_val;

  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    cpu_rd_en;
  logic                    fill_load;

  logic                    cpu_in_range;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic                    rd_in_range;
  logic [IDX_W-1:0]        rd_idx;
  logic [IDX_W-1:0]        wr_idx;

  // The single read port is steered to the video address whenever video
  // reads; a CPU read is only launched in cycles where vid_ren is low.
  assign cpu_in_range = (cpu_addr <= LAST_ADDR);
  assign rd_addr      = vid_ren ? vid_addr : cpu_addr;
  assign rd_in_range  = (rd_addr <= LAST_ADDR);
  assign rd_idx       = rd_addr[IDX_W-1:0];
  assign wr_idx       = wr_addr[IDX_W-1:0];

  assign cpu_ready = (state == ACK);
  assign fill_busy = (state == FILL);

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and write-port/read-launch control.
  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    wr_addr    = cpu_addr;
    wr_data    = cpu_wdata;
    cpu_rd_en  = 1'b0;
    fill_load  = 1'b0;
    case (state)
      IDLE: begin
        if (fill_start) begin
          // Fill takes precedence; any CPU request simply stays pending.
          fill_load  = 1'b1;
          state_next = FILL;
        end else if (cpu_valid && cpu_we) begin
          // Out-of-range writes are acknowledged but dropped.
          wr_en      = cpu_in_range;
          state_next = ACK;
        end else if (cpu_valid && !vid_ren) begin
          cpu_rd_en  = 1'b1;
          state_next = ACK;
        end
      end
      ACK: begin
        state_next = IDLE;
      end
      FILL: begin
        wr_en   = 1'b1;
        wr_addr = fill_cnt;
        wr_data = fill_val;
        if (fill_cnt == LAST_ADDR) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Fill engine: captures the value at start and walks the address range.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fill_cnt <= '0;
      fill_val <= '0;
    end else if (fill_load) begin
      fill_cnt <= '0;
      fill_val <= fill_value;
    end else if (state == FILL && fill_cnt != LAST_ADDR) begin
      fill_cnt <= fill_cnt + ADDR_WIDTH'(1);
    end
  end

  // Storage write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Registered read port; a same-address write in the same edge yields old data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vid_rdata <= '0;
      cpu_rdata <= '0;
    end else begin
      if (vid_ren) begin
        vid_rdata <= rd_in_range ? mem[rd_idx] : '0;
      end
      if (cpu_rd_en) begin
        cpu_rdata <= rd_in_range ? mem[rd_idx] : '0;
      end
    end
  end

endmodule

// File: tb/tb_tile_map_ram.sv
// Self-checking bench for tile_map_ram: random traffic against an array model.
module tb_tile_map_ram;

  localparam int DW    = 6;
  localparam int AW    = 12;
  localparam int DEPTH = 4000;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          vid_ren = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic [DW-1:0] vid_rdata;
  logic          cpu_valid = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ready;
  logic          fill_start = 1'b0;
  logic [DW-1:0] fill_value = '0;
  logic          fill_busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: what each map entry should hold, and whether it is known yet.
  logic [DW-1:0] ref_mem   [DEPTH];
  bit            ref_known [DEPTH];
  logic [AW-1:0] known_q [$];

  tile_map_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .vid_ren(vid_ren), .vid_addr(vid_addr), .vid_rdata(vid_rdata),
    .cpu_valid(cpu_valid), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .fill_start(fill_start), .fill_value(fill_value), .fill_busy(fill_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    return (int'(a) < DEPTH) ? ref_mem[a] : '0;
  endfunction

  function automatic void model_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (int'(a) < DEPTH) begin
      ref_mem[a]   = d;
      ref_known[a] = 1'b1;
    end
  endfunction

  function automatic void model_fill(input logic [DW-1:0] d, input int upto);
    for (int i = 0; i < upto; i++) begin
      ref_mem[i]   = d;
      ref_known[i] = 1'b1;
    end
  endfunction

  // One CPU transaction; starts just after a rising edge, ends just after one.
  task automatic cpu_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         output logic [DW-1:0] rdata, output int cycles);
    cpu_valid = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    cycles = 0;
    while (cycles < 6000) begin
      @(negedge clk);
      cycles++;
      if (cpu_ready) break;
    end
    if (!cpu_ready) cycles = -1;
    rdata = cpu_rdata;
    @(posedge clk); #1;
    cpu_valid = 1'b0; cpu_we = 1'b0;
  endtask

  // One isolated video read; returns the registered data one cycle later.
  task automatic vid_read(input logic [AW-1:0] addr, output logic [DW-1:0] data);
    vid_ren = 1'b1; vid_addr = addr;
    @(posedge clk); #1;
    vid_ren = 1'b0;
    @(negedge clk);
    data = vid_rdata;
    @(posedge clk); #1;
  endtask

  // Follows a running fill until fill_busy drops, optionally injecting a CPU
  // write and a fill_start pulse at given busy-cycle counts.
  task automatic fill_watch(input int cpu_at, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                            input int restart_at, output int busy_cnt, output bit ready_seen);
    busy_cnt = 0; ready_seen = 1'b0;
    for (int i = 0; i < DEPTH + 50; i++) begin
      @(negedge clk);
      if (!fill_busy) break;
      busy_cnt++;
      if (cpu_ready) ready_seen = 1'b1;
      if (busy_cnt == cpu_at) begin
        cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = ca; cpu_wdata = cd;
      end
      if (busy_cnt == restart_at) begin
        fill_start = 1'b1; fill_value = ~fill_value;
      end
      if (busy_cnt == restart_at + 1) fill_start = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (vid_rdata !== '0) begin n_fail++; $display("FAIL reset_vid_rdata: got %h want 00", vid_rdata); end
    n_checks++; if (cpu_rdata !== '0) begin n_fail++; $display("FAIL reset_cpu_rdata: got %h want 00", cpu_rdata); end
    n_checks++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_ready: got %b want 0", cpu_ready); end
    n_checks++; if (fill_busy !== 1'b0) begin n_fail++; $display("FAIL reset_fill_busy: got %b want 0", fill_busy); end
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_cpu_rw();
    logic [DW-1:0] rd, d, vd;
    logic [AW-1:0] a;
    int cyc;
    cpu_txn(1'b1, 12'h010, 6'h2A, rd, cyc);
    model_write(12'h010, 6'h2A); known_q.push_back(12'h010);
    n_checks++; if (cyc !== 2) begin n_fail++; $display("FAIL wr_cycles: got %0d want 2", cyc); end
    cpu_txn(1'b0, 12'h010, '0, rd, cyc);
    n_checks++; if (cyc !== 2) begin n_fail++; $display("FAIL rd_cycles: got %0d want 2", cyc); end
    n_checks++; if (rd !== 6'h2A) begin n_fail++; $display("FAIL rd_0x010: got %h want 2a", rd); end
    @(negedge clk);
    n_checks++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL ready_single_pulse: got %b want 0", cpu_ready); end
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      a = AW'($urandom_range(0, DEPTH - 1));
      if (a == 12'h010) a = 12'h011;
      d = DW'($urandom_range(0, 63));
      cpu_txn(1'b1, a, d, rd, cyc);
      model_write(a, d); known_q.push_back(a);
      n_checks++; if (cyc !== 2) begin n_fail++; $display("FAIL rand_wr_cycles: got %0d want 2", cyc); end
    end
    for (int i = 0; i < 16; i++) begin
      a = known_q[$urandom_range(0, known_q.size() - 1)];
      cpu_txn(1'b0, a, '0, rd, cyc);
      n_checks++; if (rd !== model_read(a)) begin n_fail++; $display("FAIL rand_cpu_rd[%h]: got %h want %h", a, rd, model_read(a)); end
      vid_read(a, vd);
      n_checks++; if (vd !== model_read(a)) begin n_fail++; $display("FAIL rand_vid_rd[%h]: got %h want %h", a, vd, model_read(a)); end
    end
  endtask

  task automatic test_read_during_write();
    logic [AW-1:0] a;
    logic [DW-1:0] old, nv, vd, rd;
    int cyc;
    a = known_q[0]; old = model_read(a); nv = old ^ 6'h15;
    cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = nv;
    vid_ren = 1'b1; vid_addr = a;
    @(posedge clk); #1;
    vid_ren = 1'b0;
    @(negedge clk);
    n_checks++; if (vid_rdata !== old) begin n_fail++; $display("FAIL rdw_old_data: got %h want %h", vid_rdata, old); end
    n_checks++; if (cpu_ready !== 1'b1) begin n_fail++; $display("FAIL rdw_write_ack: got %b want 1", cpu_ready); end
    @(posedge clk); #1;
    cpu_valid = 1'b0; cpu_we = 1'b0;
    model_write(a, nv);
    vid_read(a, vd);
    n_checks++; if (vd !== nv) begin n_fail++; $display("FAIL rdw_new_data: got %h want %h", vd, nv); end
    cpu_txn(1'b0, a, '0, rd, cyc);
    n_checks++; if (rd !== nv) begin n_fail++; $display("FAIL rdw_cpu_readback: got %h want %h", rd, nv); end
  endtask

  task automatic test_vid_priority();
    logic [AW-1:0] a_prev, a_next;
    logic [DW-1:0] exp_rd, hold;
    bit ready_in_stall;
    int cyc;
    exp_rd = model_read(12'h010);
    ready_in_stall = 1'b0;
    cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h010;
    a_prev = known_q[$urandom_range(0, known_q.size() - 1)];
    vid_ren = 1'b1; vid_addr = a_prev;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      a_next = known_q[$urandom_range(0, known_q.size() - 1)];
      vid_addr = a_next;
      @(negedge clk);
      n_checks++; if (vid_rdata !== model_read(a_prev)) begin n_fail++; $display("FAIL vid_stream[%h]: got %h want %h", a_prev, vid_rdata, model_read(a_prev)); end
      if (cpu_ready) ready_in_stall = 1'b1;
      a_prev = a_next;
    end
    n_checks++; if (ready_in_stall !== 1'b0) begin n_fail++; $display("FAIL cpu_stall: cpu_ready seen=%b want 0", ready_in_stall); end
    @(posedge clk); #1;
    vid_ren = 1'b0;
    hold = model_read(a_prev);
    cyc = 0;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cpu_ready) break;
    end
    n_checks++; if (cyc !== 2) begin n_fail++; $display("FAIL stall_release_cycles: got %0d want 2", cyc); end
    n_checks++; if (cpu_rdata !== exp_rd) begin n_fail++; $display("FAIL stall_rdata: got %h want %h", cpu_rdata, exp_rd); end
    n_checks++; if (vid_rdata !== hold) begin n_fail++; $display("FAIL vid_hold: got %h want %h", vid_rdata, hold); end
    @(posedge clk); #1;
    cpu_valid = 1'b0;
  endtask

  task automatic test_out_of_range();
    logic [DW-1:0] rd, vd;
    int cyc;
    cpu_txn(1'b1, 12'h000, 6'h15, rd, cyc);
    model_write(12'h000, 6'h15);
    vid_read(12'h000, vd);
    n_checks++; if (vd !== 6'h15) begin n_fail++; $display("FAIL oor_pre_vid: got %h want 15", vd); end
    cpu_txn(1'b1, 12'hFA0, 6'h3C, rd, cyc);
    n_checks++; if (cyc !== 2) begin n_fail++; $display("FAIL oor_wr_cycles: got %0d want 2", cyc); end
    cpu_txn(1'b0, 12'hFA0, '0, rd, cyc);
    n_checks++; if (cyc !== 2) begin n_fail++; $display("FAIL oor_rd_cycles: got %0d want 2", cyc); end
    n_checks++; if (rd !== 6'h00) begin n_fail++; $display("FAIL oor_cpu_rd: got %h want 00", rd); end
    vid_read(12'hFA0, vd);
    n_checks++; if (vd !== 6'h00) begin n_fail++; $display("FAIL oor_vid_rd: got %h want 00", vd); end
    cpu_txn(1'b1, 12'hFFF, 6'h11, rd, cyc);
    vid_read(12'h000, vd);
    n_checks++; if (vd !== 6'h15) begin n_fail++; $display("FAIL oor_entry0: got %h want 15", vd); end
    vid_read(12'hFFF, vd);
    n_checks++; if (vd !== 6'h00) begin n_fail++; $display("FAIL oor_vid_fff: got %h want 00", vd); end
    cpu_txn(1'b0, 12'h000, '0, rd, cyc);
    n_checks++; if (rd !== 6'h15) begin n_fail++; $display("FAIL oor_cpu_entry0: got %h want 15", rd); end
  endtask

  task automatic test_fill();
    int busy_cnt;
    bit ready_seen, ack;
    logic [DW-1:0] vd;
    fill_start = 1'b1; fill_value = 6'h05;
    @(posedge clk); #1;
    fill_start = 1'b0; fill_value = 6'h3A;
    fill_watch(500, 12'h200, 6'h33, 1000, busy_cnt, ready_seen);
    n_checks++; if (busy_cnt !== DEPTH) begin n_fail++; $display("FAIL fill_busy_cycles: got %0d want %0d", busy_cnt, DEPTH); end
    n_checks++; if (ready_seen !== 1'b0) begin n_fail++; $display("FAIL fill_cpu_stall: cpu_ready seen=%b want 0", ready_seen); end
    ack = 1'b0;
    for (int j = 0; j < 10; j++) begin
      if (cpu_ready) begin ack = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL fill_cpu_ack: ack=%b want 1", ack); end
    @(posedge clk); #1;
    cpu_valid = 1'b0; cpu_we = 1'b0;
    model_fill(6'h05, DEPTH);
    model_write(12'h200, 6'h33);
    vid_read(12'd0, vd);
    n_checks++; if (vd !== 6'h05) begin n_fail++; $display("FAIL fill_entry0: got %h want 05", vd); end
    vid_read(12'd1999, vd);
    n_checks++; if (vd !== 6'h05) begin n_fail++; $display("FAIL fill_entry1999: got %h want 05", vd); end
    vid_read(12'd3999, vd);
    n_checks++; if (vd !== 6'h05) begin n_fail++; $display("FAIL fill_entry3999: got %h want 05", vd); end
    vid_read(12'h200, vd);
    n_checks++; if (vd !== 6'h33) begin n_fail++; $display("FAIL fill_midwrite: got %h want 33", vd); end
  endtask

  task automatic test_fill_collision(output logic [DW-1:0] fv, output logic [DW-1:0] wd);
    int busy_cnt, cyc;
    bit ready_seen, ack;
    logic [DW-1:0] vd, rd;
    logic [AW-1:0] a;
    fv = DW'($urandom_range(0, 63));
    do wd = DW'($urandom_range(1, 63)); while (wd == fv);
    fill_start = 1'b1; fill_value = fv;
    cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h123; cpu_wdata = wd;
    @(posedge clk); #1;
    fill_start = 1'b0; fill_value = ~fv;
    fill_watch(-1, '0, '0, -1, busy_cnt, ready_seen);
    n_checks++; if (busy_cnt !== DEPTH) begin n_fail++; $display("FAIL coll_busy_cycles: got %0d want %0d", busy_cnt, DEPTH); end
    n_checks++; if (ready_seen !== 1'b0) begin n_fail++; $display("FAIL coll_cpu_stall: cpu_ready seen=%b want 0", ready_seen); end
    ack = 1'b0;
    for (int j = 0; j < 10; j++) begin
      if (cpu_ready) begin ack = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL coll_cpu_ack: ack=%b want 1", ack); end
    @(posedge clk); #1;
    cpu_valid = 1'b0; cpu_we = 1'b0;
    model_fill(fv, DEPTH);
    model_write(12'h123, wd);
    vid_read(12'h123, vd);
    n_checks++; if (vd !== wd) begin n_fail++; $display("FAIL coll_cpu_wins: got %h want %h", vd, wd); end
    for (int i = 0; i < 3; i++) begin
      a = AW'($urandom_range(0, DEPTH - 1));
      vid_read(a, vd);
      n_checks++; if (vd !== model_read(a)) begin n_fail++; $display("FAIL coll_fill_entry[%h]: got %h want %h", a, vd, model_read(a)); end
    end
    a = AW'($urandom_range(0, DEPTH - 1));
    cpu_txn(1'b0, a, '0, rd, cyc);
    n_checks++; if (rd !== model_read(a)) begin n_fail++; $display("FAIL coll_cpu_rd[%h]: got %h want %h", a, rd, model_read(a)); end
  endtask

  task automatic test_reset_mid_fill(input logic [DW-1:0] fv, input logic [DW-1:0] wd);
    logic [DW-1:0] fv2, fv3, vd;
    int busy_cnt;
    bit ready_seen;
    fv2 = fv ^ 6'h21;
    vid_ren = 1'b1; vid_addr = 12'h123;
    fill_start = 1'b1; fill_value = fv2;
    @(posedge clk); #1;
    fill_start = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (fill_busy) busy_cnt++;
      if (busy_cnt == 100) break;
    end
    n_checks++; if (vid_rdata !== wd) begin n_fail++; $display("FAIL rst_pre_vid: got %h want %h", vid_rdata, wd); end
    @(posedge clk); #1;
    resetn = 1'b0; vid_ren = 1'b0;
    #1;
    n_checks++; if (fill_busy !== 1'b0) begin n_fail++; $display("FAIL rst_fill_busy: got %b want 0", fill_busy); end
    n_checks++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cpu_ready: got %b want 0", cpu_ready); end
    n_checks++; if (vid_rdata !== '0) begin n_fail++; $display("FAIL rst_vid_rdata: got %h want 00", vid_rdata); end
    n_checks++; if (cpu_rdata !== '0) begin n_fail++; $display("FAIL rst_cpu_rdata: got %h want 00", cpu_rdata); end
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    model_fill(fv2, 100);
    vid_read(12'd0, vd);
    n_checks++; if (vd !== fv2) begin n_fail++; $display("FAIL rst_entry0: got %h want %h", vd, fv2); end
    vid_read(12'd99, vd);
    n_checks++; if (vd !== fv2) begin n_fail++; $display("FAIL rst_entry99: got %h want %h", vd, fv2); end
    vid_read(12'd100, vd);
    n_checks++; if (vd !== model_read(12'd100)) begin n_fail++; $display("FAIL rst_entry100: got %h want %h", vd, model_read(12'd100)); end
    fv3 = fv2 ^ 6'h0C;
    fill_start = 1'b1; fill_value = fv3;
    @(posedge clk); #1;
    fill_start = 1'b0;
    fill_watch(-1, '0, '0, -1, busy_cnt, ready_seen);
    n_checks++; if (busy_cnt !== DEPTH) begin n_fail++; $display("FAIL refill_busy_cycles: got %0d want %0d", busy_cnt, DEPTH); end
    @(posedge clk); #1;
    model_fill(fv3, DEPTH);
    vid_read(12'd100, vd);
    n_checks++; if (vd !== fv3) begin n_fail++; $display("FAIL refill_entry100: got %h want %h", vd, fv3); end
    vid_read(12'd3999, vd);
    n_checks++; if (vd !== fv3) begin n_fail++; $display("FAIL refill_entry3999: got %h want %h", vd, fv3); end
  endtask

  initial begin
    logic [DW-1:0] fv, wd;
    test_reset();
    test_cpu_rw();
    test_read_during_write();
    test_vid_priority();
    test_out_of_range();
    test_fill();
    test_fill_collision(fv, wd);
    test_reset_mid_fill(fv, wd);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
